// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-ROM port and the IF/ID outputs to decode.
// master = fetch_stage side, slave = surrounding pipeline (hazard unit, EX, ROM, decode).
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    input  stall, redirect, redirect_pc, irom_inst,
    output irom_addr, id_inst, id_pc, id_pc4, id_valid
  );

  modport slave (
    output stall, redirect, redirect_pc, irom_inst,
    input  irom_addr, id_inst, id_pc, id_pc4, id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// miniRV instruction fetch + IF/ID register. Priority: reset > redirect > stall > sequential.
// Optional FETCH_PERF_EN adds fetch/stall/flush counters with a synchronous clear.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  input  logic          perf_clr,
  output logic [31:0]   perf_fetch,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_flush
`endif
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

  logic [31:0] pc_q, pc_d, pc_plus4;
  ifid_t       ifid_q, ifid_d;
  logic        load_ok;

  // Target low bits are discarded: fetch is always word aligned.
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^bus.redirect_pc[1:0];

  assign pc_plus4 = pc_q + 32'd4;
  assign load_ok  = !bus.redirect && !bus.stall;

  always_comb begin
    pc_d   = pc_plus4;
    ifid_d = '{inst: bus.irom_inst, pc: pc_q, pc4: pc_plus4, valid: 1'b1};
    if (bus.redirect) begin
      pc_d   = {bus.redirect_pc[31:2], 2'b00};
      ifid_d = IFID_BUBBLE;
    end else if (bus.stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pc_q   <= RESET_PC;
      ifid_q <= IFID_BUBBLE;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.irom_addr = pc_q;
  assign bus.id_inst   = ifid_q.inst;
  assign bus.id_pc     = ifid_q.pc;
  assign bus.id_pc4    = ifid_q.pc4;
  assign bus.id_valid  = ifid_q.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_q, fetch_d, stall_q, stall_d, flush_q, flush_d;

  // Clear wins over that same edge's increment.
  always_comb begin
    fetch_d = fetch_q + {31'd0, load_ok};
    stall_d = stall_q + {31'd0, bus.stall && !bus.redirect};
    flush_d = flush_q + {31'd0, bus.redirect};
    if (perf_clr) begin
      fetch_d = 32'd0;
      stall_d = 32'd0;
      flush_d = 32'd0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      fetch_q <= 32'd0;
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign perf_fetch = fetch_q;
  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  logic unused_load_ok;
  assign unused_load_ok = load_ok;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, redirect (+stall), PC wrap, async reset.
// ROM model: addr 0 holds 32'h00500093, every other word holds addr ^ 32'hA500_0000.
module tb_fetch_stage;
  logic cpu_clk = 1'b0;
  logic cpu_rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  fetch_stage_if bus ();

`ifdef FETCH_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  fetch_stage dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .bus       (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_clr  (perf_clr),
    .perf_fetch(perf_fetch),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hA500_0000);
  endfunction

  assign bus.irom_inst = rom(bus.irom_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [31:0] pc4, input logic vld);
    chk({tag, ".addr"},  bus.irom_addr, addr);
    chk({tag, ".inst"},  bus.id_inst,   inst);
    chk({tag, ".pc"},    bus.id_pc,     pc);
    chk({tag, ".pc4"},   bus.id_pc4,    pc4);
    chk({tag, ".valid"}, {31'd0, bus.id_valid}, {31'd0, vld});
  endtask

`ifdef FETCH_PERF_EN
  task automatic chk_perf(input string tag, input logic [31:0] f, input logic [31:0] s, input logic [31:0] fl);
    chk({tag, ".fetch"}, perf_fetch, f);
    chk({tag, ".stall"}, perf_stall, s);
    chk({tag, ".flush"}, perf_flush, fl);
  endtask
`endif

  initial begin
    cpu_rst_n       = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
`ifdef FETCH_PERF_EN
    perf_clr        = 1'b0;
`endif
    tick();
    tick();
    chk_id("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    chk_perf("reset", 0, 0, 0);
`endif
    cpu_rst_n = 1'b1;

    tick();
    chk_id("first", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    tick();
    chk_id("seq", 32'h8, 32'hA500_0004, 32'h4, 32'h8, 1'b1);

    bus.stall = 1'b1;
    tick();
    chk_id("stall1", 32'h8, 32'hA500_0004, 32'h4, 32'h8, 1'b1);
    tick();
    chk_id("stall2", 32'h8, 32'hA500_0004, 32'h4, 32'h8, 1'b1);
    bus.stall = 1'b0;
    tick();
    chk_id("resume", 32'hC, 32'hA500_0008, 32'h8, 32'hC, 1'b1);

    // Redirect with stall also asserted: redirect must win.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    bus.stall       = 1'b1;
    tick();
    chk_id("redir", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0);
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    tick();
    chk_id("target", 32'h104, 32'hA500_0100, 32'h100, 32'h104, 1'b1);
`ifdef FETCH_PERF_EN
    chk_perf("cnt1", 4, 2, 1);
`endif

    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    chk_id("redir_top", 32'hFFFF_FFFC, 32'h13, 32'h0, 32'h0, 1'b0);
    bus.redirect = 1'b0;
    tick();
    chk_id("wrap", 32'h0, 32'h5AFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
`ifdef FETCH_PERF_EN
    chk_perf("cnt2", 5, 2, 2);
    perf_clr  = 1'b1;
    bus.stall = 1'b1;
    tick();
    chk_perf("clr", 0, 0, 0);
    perf_clr  = 1'b0;
    bus.stall = 1'b0;
`endif
    tick();
    chk_id("post_wrap", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1);

    bus.stall = 1'b1;
    tick();
    chk("pre_rst.addr", bus.irom_addr, 32'h4);
    // Asynchronous reset in mid-stall, away from any clock edge.
    cpu_rst_n = 1'b0;
    #1;
    chk_id("async_rst", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_EN
    chk_perf("async_rst", 0, 0, 0);
`endif
    #2;
    cpu_rst_n = 1'b1;
    bus.stall = 1'b0;
    tick();
    chk_id("rst_again", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
